// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone burst master.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {IDLE, FETCH, BUS} wb_mst_state_e;

  // Cycle type for a beat, given whether the command is a burst and the beat is its last.
  function automatic logic [2:0] cti_for(input logic burst, input logic last);
    if (!burst) return CTI_CLASSIC;
    return last ? CTI_EOB : CTI_INCR;
  endfunction

endpackage

// File: rtl/wb_burst_master_if.sv
// Command, write-stream, read-stream and Wishbone signals of the burst master.
interface wb_burst_master_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned BL_WIDTH   = 8
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_we;
  logic [ADDR_WIDTH-1:0]     cmd_addr;
  logic [BL_WIDTH-1:0]       cmd_bl;
  logic [DATA_WIDTH/8-1:0]   cmd_sel;
  logic                      wdata_valid;
  logic                      wdata_ready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic                      rdata_valid;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      rdata_last;
  logic                      done;
  logic                      err;
  logic                      wb_cyc;
  logic                      wb_stb;
  logic                      wb_we;
  logic [ADDR_WIDTH-1:0]     wb_addr;
  logic [DATA_WIDTH-1:0]     wb_dat_wr;
  logic [DATA_WIDTH/8-1:0]   wb_sel;
  logic [2:0]                wb_cti;
  logic                      wb_ack;
  logic [DATA_WIDTH-1:0]     wb_dat_rd;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_bl, cmd_sel, wdata_valid, wdata, wb_ack, wb_dat_rd,
    output cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, done, err,
    output wb_cyc, wb_stb, wb_we, wb_addr, wb_dat_wr, wb_sel, wb_cti
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_bl, cmd_sel, wdata_valid, wdata, wb_ack, wb_dat_rd,
    input  cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, done, err,
    input  wb_cyc, wb_stb, wb_we, wb_addr, wb_dat_wr, wb_sel, wb_cti
  );

endinterface

// File: rtl/wb_ack_watchdog.sv
// Counts consecutive enabled cycles; expired is high on the LIMIT-th such cycle.
module wb_ack_watchdog #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(LIMIT + 1);

  logic [CntW-1:0] cnt_q;

  assign expired = en && (cnt_q == CntW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 burst master: commands plus write stream in, classic/incrementing bursts out.
// Define WB_BURST_TIMEOUT_EN to abort a command after TIMEOUT_CYCLES cycles without ack.
module wb_burst_master
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 26,
  parameter int unsigned BL_WIDTH       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  wb_burst_master_if.master bus
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(SEL_WIDTH);

  if (((DATA_WIDTH % 8) != 0) || (TIMEOUT_CYCLES == 0)) begin : g_bad_param
    $error("wb_burst_master: DATA_WIDTH must be a multiple of 8 and TIMEOUT_CYCLES nonzero");
  end

  wb_mst_state_e         state_q, state_d;
  logic                  run_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BL_WIDTH-1:0]   rem_q, rem_d;
  logic                  burst_q, burst_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  we_q, we_d, cyc_q, cyc_d, stb_q, stb_d;
  logic [2:0]            cti_q, cti_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d, rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic                  done_q, done_d, err_q, err_d;
  logic                  cmd_ready, wdata_ready, cmd_fire, cmd_burst, ack_bus, last_beat;
  logic                  timeout;

  assign cmd_fire  = bus.cmd_valid && cmd_ready;
  assign cmd_burst = bus.cmd_bl > BL_WIDTH'(1);
  assign ack_bus   = (state_q == BUS) && bus.wb_ack;
  assign last_beat = rem_q == BL_WIDTH'(1);

`ifdef WB_BURST_TIMEOUT_EN
  logic wdog_expired;

  wb_ack_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_i),
    .clr    ((state_q != BUS) || bus.wb_ack),
    .en     ((state_q == BUS) && !bus.wb_ack),
    .expired(wdog_expired)
  );

  assign timeout = wdog_expired;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_fire) state_d = bus.cmd_we ? FETCH : BUS;
      FETCH:   if (bus.wdata_valid) state_d = BUS;
      BUS: begin
        if (ack_bus) begin
          if (last_beat)                     state_d = IDLE;
          else if (we_q && !bus.wdata_valid) state_d = FETCH;
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = run_q && (state_q == IDLE);
    wdata_ready = (state_q == FETCH) || (ack_bus && we_q && !last_beat);
  end

  always_comb begin
    addr_d   = addr_q;
    rem_d    = rem_q;
    burst_d  = burst_q;
    sel_d    = sel_q;
    we_d     = we_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    cti_d    = cti_q;
    dat_d    = dat_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    rlast_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: if (cmd_fire) begin
        addr_d  = bus.cmd_addr;
        rem_d   = (bus.cmd_bl == '0) ? BL_WIDTH'(1) : bus.cmd_bl;
        burst_d = cmd_burst;
        sel_d   = bus.cmd_sel;
        we_d    = bus.cmd_we;
        cyc_d   = 1'b1;
        stb_d   = !bus.cmd_we;
        if (!bus.cmd_we) cti_d = cti_for(cmd_burst, !cmd_burst);
      end
      FETCH: if (bus.wdata_valid) begin
        dat_d = bus.wdata;
        stb_d = 1'b1;
        cti_d = cti_for(burst_q, last_beat);
      end
      BUS: begin
        if (ack_bus) begin
          if (!we_q) begin
            rdata_d  = bus.wb_dat_rd;
            rvalid_d = 1'b1;
            rlast_d  = last_beat;
          end
          if (last_beat) begin
            done_d = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_STEP;
            rem_d  = rem_q - BL_WIDTH'(1);
            // A write with no beat ready parks in FETCH with stb low and cti unchanged.
            if (we_q && !bus.wdata_valid) begin
              stb_d = 1'b0;
            end else begin
              cti_d = cti_for(burst_q, rem_q == BL_WIDTH'(2));
              if (we_q) dat_d = bus.wdata;
            end
          end
        end else if (timeout) begin
          err_d = 1'b1;
        end
        if ((ack_bus && last_beat) || (!ack_bus && timeout)) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          we_d  = 1'b0;
          sel_d = '0;
          dat_d = '0;
          cti_d = CTI_CLASSIC;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      addr_q   <= '0;
      rem_q    <= '0;
      burst_q  <= 1'b0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      cti_q    <= CTI_CLASSIC;
      dat_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      burst_q  <= burst_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      cti_q    <= cti_d;
      dat_q    <= dat_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.wdata_ready = wdata_ready;
  assign bus.rdata_valid = rvalid_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_last  = rlast_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.wb_cyc      = cyc_q;
  assign bus.wb_stb      = stb_q;
  assign bus.wb_we       = we_q;
  assign bus.wb_addr     = addr_q;
  assign bus.wb_dat_wr   = dat_q;
  assign bus.wb_sel      = sel_q;
  assign bus.wb_cti      = cti_q;

endmodule

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
Synthesizable, parametrised Wishbone B3 master engine that replaces task-driven bus access. It accepts commands with address, beat count and direction, plus streamed write data. It runs classic or incrementing-burst cycles (CTI) toward the SDRAM controller's Wishbone slave port and returns read data as a stream. It sits between test/traffic generators or a CPU bridge and the sdr_ctrl Wishbone slave.

Parameters:
DATA_WIDTH, 32, Wishbone data width; must be a multiple of 8.
ADDR_WIDTH, 26, Wishbone byte address width.
BL_WIDTH, 8, width of the beat-count field.
TIMEOUT_CYCLES, 256, ack watchdog limit; used only with the optional feature.

Ports:
wb_clk_i  in  1  clock; all logic on rising edge
wb_rst_i  in  1  reset, asynchronous assert, active-low
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_we_i  in  1  1=write, 0=read
cmd_addr_i  in  ADDR_WIDTH  start byte address
cmd_bl_i  in  BL_WIDTH  beat count; 0 treated as 1
cmd_sel_i  in  DATA_WIDTH/8  byte select, applied to every beat
wdata_valid_i  in  1  write beat valid
wdata_ready_o  out  1  write beat taken when valid&ready
wdata_i  in  DATA_WIDTH  write beat data
rdata_valid_o  out  1  read beat valid; no backpressure
rdata_o  out  DATA_WIDTH  read beat data
rdata_last_o  out  1  final read beat of command
done_o  out  1  one-cycle pulse, command complete
err_o  out  1  one-cycle pulse, command aborted (timeout)
wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone cycle/strobe/write
wb_addr_o  out  ADDR_WIDTH  Wishbone address
wb_dat_o  out  DATA_WIDTH  Wishbone write data
wb_sel_o  out  DATA_WIDTH/8  Wishbone byte select
wb_cti_o  out  3  cycle type identifier
wb_ack_i  in  1  slave acknowledge
wb_dat_i  in  DATA_WIDTH  slave read data

Behaviour:
- Reset (wb_rst_i low): all outputs 0 immediately, cmd_ready_o=0, state IDLE, counters 0. Release takes effect at the next edge. Reset mid-burst drops cyc/stb at once, with no done_o and no err_o.
- States:
  - IDLE: cmd_ready_o=1. On accept, latch addr/bl/sel/we. Write goes to FETCH; read goes to BUS.
  - FETCH: wdata_ready_o=1, cyc=1, stb=0. A beat taken moves to BUS next cycle.
  - BUS: cyc=stb=1. Stay in BUS until wb_ack_i.
- All Wishbone outputs are registered. First stb is asserted the cycle after command accept (read) or after the write beat is taken.
- On ack in BUS (non-final beat):
  - address advances by DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH;
  - remaining-beat count decrements.
  - Write: wdata_ready_o is asserted combinationally in the ack cycle. If a beat is taken, stay in BUS with no stb gap. If not, go to FETCH: stb=0, cyc held, cti held.
  - Read: stay in BUS.
- Final ack: cyc/stb/we drop next cycle, state goes to IDLE, and done_o pulses that same next cycle. cmd_ready_o=1 in that cycle, so back-to-back commands are allowed.
- CTI:
  - single beat: 000 (classic);
  - multi-beat: 010 on every beat except the last, 111 on the last beat.
- Read beat handling: on each read ack, wb_dat_i is registered. rdata_valid_o is asserted the next cycle; rdata_last_o is set with the final beat, coincident with done_o.
- wb_we_o=0, wb_sel_o=0, wb_dat_o=0 whenever cyc=0.

Optional Feature:
WB_BURST_TIMEOUT_EN:
- Defined: a watchdog counts consecutive BUS cycles without ack. On reaching TIMEOUT_CYCLES:
  - cyc/stb drop next cycle;
  - err_o pulses instead of done_o;
  - remaining beats are discarded;
  - return to IDLE;
  - a partial read keeps its already-delivered beats, with no rdata_last_o.
- Undefined: err_o is tied 0 and the block waits for ack indefinitely.

Decomposition:
- Package wb_pkg holds:
  - CTI constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111;
  - state enum wb_mst_state_e {IDLE, FETCH, BUS}.
- Sub-module wb_ack_watchdog (counter with clear, enable and expired output) is instantiated only under the macro.

Test Plan:
- Write, bl=1, addr 0x100, data 0xDEADBEEF, ack after 2 waits -> one cycle with cti 000, sel 1111, we=1; done_o one cycle after ack.
- Read, bl=4, addr 0x200, single-cycle acks returning 1,2,3,4 -> addresses 0x200/204/208/20C; cti 010,010,010,111; four consecutive rdata_valid_o, last with rdata_last_o and done_o.
- Write, bl=3, wdata_valid_i low 2 cycles before beat 2 -> stb low 2 cycles, cyc high, cti stays 010; data order preserved.
- Read, bl=2, addr 0x3FFFFFC -> second beat at address 0x0000000.
- Reset asserted in beat 2 of a 4-beat read -> cyc/stb/outputs 0 without a clock edge; no done_o; next command runs normally.
- With WB_BURST_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never acks -> cyc drops after 16 stb cycles; err_o pulses; cmd_ready_o returns to 1.
